// File: rtl/branch_resolve.sv
// EX-stage branch resolution: actual next PC, mispredict redirect handshake, timed flush.
// Optional resolved/mispredict counters are built when BRANCH_STATS_EN is defined.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CTR_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      cmp_f,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall_ex,
  output logic             trap_misalign,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic [CTR_W-1:0] stat_br,
  output logic [CTR_W-1:0] stat_mis
);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_q;
  logic             trap_q;
  logic             upd_valid_q;
  logic [31:0]      upd_pc_q;
  logic [31:0]      upd_target_q;
  logic             upd_taken_q;

  logic        resolve;
  logic        use_cmp;
  logic [31:0] target;
  logic        taken;
  logic [31:0] next_pc;
  logic        misalign;
  logic        mispredict;
  logic        redirect_req;

  // Only the condition bit of the comparator result matters here.
  logic unused_cmp_hi;
  assign unused_cmp_hi = ^cmp_f[31:1];

  assign stall_ex     = (state_q != IDLE);
  assign resolve      = ex_valid & ~stall_ex & (ex_is_br | ex_is_jal | ex_is_jalr);
  assign use_cmp      = ex_is_br & ~ex_is_jal & ~ex_is_jalr;
  assign target       = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
  assign taken        = use_cmp ? cmp_f[0] : 1'b1;
  assign next_pc      = taken ? target : (ex_pc + 32'd4);
  assign misalign     = taken & (target[1:0] != 2'b00);
  assign mispredict   = (taken != ex_pred_taken) | (taken & (target != ex_pred_target));
  assign redirect_req = resolve & mispredict & ~misalign;

  // NOTE: state is written with <= only, so every flop samples pre-edge values
  // regardless of the order statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect_req) begin
            state_q          <= REQ;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= next_pc;
            flush_q          <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_ready) begin
            state_q          <= FLUSH;
            redirect_valid_q <= 1'b0;
            cnt_q            <= CNT_LAST;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  // Update payload holds its last value between pulses; only the pulse is qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q  <= 1'b0;
      trap_q       <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      upd_valid_q <= resolve;
      trap_q      <= resolve & misalign;
      if (resolve) begin
        upd_pc_q     <= ex_pc;
        upd_target_q <= target;
        upd_taken_q  <= taken;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign trap_misalign  = trap_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_target_q;
  assign upd_taken      = upd_taken_q;

`ifdef BRANCH_STATS_EN
  logic [CTR_W-1:0] stat_br_q, stat_br_d;
  logic [CTR_W-1:0] stat_mis_q, stat_mis_d;

  // NOTE: each next-state value gets a default first so no latch is inferred.
  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (resolve)      stat_br_d  = stat_br_q + CTR_W'(1);
    if (redirect_req) stat_mis_d = stat_mis_q + CTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_br  = stat_br_q;
  assign stat_mis = stat_mis_q;
`else
  assign stat_br  = '0;
  assign stat_mis = '0;
`endif

endmodule
